// File: rtl/riscv_dmem_if.sv
// -----------------------------------------------------------------------------
// riscv_dmem_if
// Data-memory interface placed after the load/store unit. LSU access pulses are
// queued in order and each request becomes one transaction on a split
// address/response bus, with at most one transaction outstanding. Completions
// go back to the LSU/WB path as a one-cycle ack. The ack carries LSB-aligned,
// zero-extended load data and misaligned/bus-error status.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   mem_req           LSU access pulse (mem_adr, mem_d, mem_we, mem_size)
//   mem_flush         drop all queued, unissued requests
//   mem_full          queue holds DEPTH entries
//   mem_ack           completion pulse, in push order
//   mem_q             load data (0 for stores, errors, misaligned)
//   mem_misaligned    qualifies mem_ack: access not naturally aligned
//   mem_err           qualifies mem_ack: bus reported an error
//   bus_req/bus_gnt   address phase handshake (bus_adr, bus_we, bus_size)
//   bus_d             store data, held until the response phase ends
//   bus_rvalid        response phase complete (bus_q, bus_err)
// -----------------------------------------------------------------------------
module riscv_dmem_if #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_req,
    input  logic [XLEN-1:0] mem_adr,
    input  logic [XLEN-1:0] mem_d,
    input  logic            mem_we,
    input  logic [2:0]      mem_size,
    input  logic            mem_flush,
    output logic            mem_full,
    output logic            mem_ack,
    output logic [XLEN-1:0] mem_q,
    output logic            mem_misaligned,
    output logic            mem_err,
    output logic            bus_req,
    output logic [XLEN-1:0] bus_adr,
    output logic            bus_we,
    output logic [2:0]      bus_size,
    output logic [XLEN-1:0] bus_d,
    input  logic            bus_gnt,
    input  logic            bus_rvalid,
    input  logic [XLEN-1:0] bus_q,
    input  logic            bus_err
);

    localparam logic [2:0] SZ_BYTE  = 3'd0;
    localparam logic [2:0] SZ_HWORD = 3'd1;
    localparam logic [2:0] SZ_WORD  = 3'd2;
    localparam logic [2:0] SZ_DWORD = 3'd3;
    localparam logic [2:0] SZ_UNDEF = 3'd7;

    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int OFFW = $clog2(XLEN / 8);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // Natural alignment; DWORD exists only on a 64-bit bus.
    function automatic logic f_aligned(input logic [2:0] a, input logic [2:0] size);
        logic ok;
        case (size)
            SZ_BYTE:  ok = 1'b1;
            SZ_HWORD: ok = (a[0] == 1'b0);
            SZ_WORD:  ok = (a[1:0] == 2'b00);
            SZ_DWORD: ok = (XLEN == 64) && (a == 3'b000);
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Move the addressed byte lane down to bit 0 and zero-extend to the size.
    function automatic logic [XLEN-1:0] f_extract(input logic [XLEN-1:0] q,
                                                  input logic [OFFW-1:0] off,
                                                  input logic [2:0]      size);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] res;
        sh = q >> {off, 3'b000};
        case (size)
            SZ_BYTE:  res = XLEN'(sh[7:0]);
            SZ_HWORD: res = XLEN'(sh[15:0]);
            SZ_WORD:  res = XLEN'(sh[31:0]);
            default:  res = sh;
        endcase
        return res;
    endfunction

    // Request queue storage (data only, no reset needed)
    logic [XLEN-1:0] r_q_adr  [DEPTH];
    logic [XLEN-1:0] r_q_d    [DEPTH];
    logic            r_q_we   [DEPTH];
    logic [2:0]      r_q_size [DEPTH];

    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_cnt;
    logic            r_full;
    logic            r_suppress;
    state_t          r_state;

    state_t          w_state_nxt;
    logic            w_push;
    logic            w_pop;
    logic            w_issue;
    logic            w_mis;
    logic            w_done;
    logic [CW-1:0]   w_cnt_nxt;
    logic [XLEN-1:0] w_head_adr;
    logic            w_head_ok;

    assign w_head_adr = r_q_adr[r_rptr];
    assign w_head_ok  = f_aligned(w_head_adr[2:0], r_q_size[r_rptr]);

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_push = mem_req && !mem_flush && (!r_full || w_pop);

    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_cnt + CW'(1);
            2'b01:   w_cnt_nxt = r_cnt - CW'(1);
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_adr[r_wptr]  <= mem_adr;
            r_q_d[r_wptr]    <= mem_d;
            r_q_we[r_wptr]   <= mem_we;
            r_q_size[r_wptr] <= mem_size;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_full <= 1'b0;
        end else if (mem_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_full <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            r_cnt  <= w_cnt_nxt;
            r_full <= (w_cnt_nxt == CW'(DEPTH));
        end
    end

    // Transaction FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_issue     = 1'b0;
        w_mis       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((r_cnt != '0) && !mem_flush) begin
                    w_pop = 1'b1;
                    if (w_head_ok) begin
                        w_issue     = 1'b1;
                        w_state_nxt = ST_ADDR;
                    end else begin
                        w_mis = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (bus_gnt) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (bus_rvalid) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Bus address/data registers: loaded on issue, held through the response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_adr  <= '0;
            bus_d    <= '0;
            bus_we   <= 1'b0;
            bus_size <= SZ_UNDEF;
        end else if (w_issue) begin
            bus_adr  <= w_head_adr;
            bus_d    <= r_q_d[r_rptr];
            bus_we   <= r_q_we[r_rptr];
            bus_size <= r_q_size[r_rptr];
        end
    end

    assign bus_req = (r_state == ST_ADDR);

    // A flush during an in-flight transaction lets it finish on the bus but
    // hides its completion from the LSU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                      r_suppress <= 1'b0;
        else if (w_done)                              r_suppress <= 1'b0;
        else if (mem_flush && (r_state != ST_IDLE))   r_suppress <= 1'b1;
    end

    // Completion outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_ack        <= 1'b0;
            mem_misaligned <= 1'b0;
            mem_err        <= 1'b0;
            mem_q          <= '0;
        end else begin
            mem_ack        <= 1'b0;
            mem_misaligned <= 1'b0;
            mem_err        <= 1'b0;
            if (w_mis) begin
                mem_ack        <= 1'b1;
                mem_misaligned <= 1'b1;
                mem_q          <= '0;
            end else if (w_done && !r_suppress && !mem_flush) begin
                mem_ack <= 1'b1;
                mem_err <= bus_err;
                if (bus_we || bus_err) mem_q <= '0;
                else                   mem_q <= f_extract(bus_q, bus_adr[OFFW-1:0], bus_size);
            end
        end
    end

    assign mem_full = r_full;

endmodule

// File: tb/tb_riscv_dmem_if.sv
// -----------------------------------------------------------------------------
// tb_riscv_dmem_if
// Directed bench for riscv_dmem_if (XLEN=64, DEPTH=2). Inputs change 1ns after
// the rising edge and outputs are sampled there as well, so each check sees the
// state registered on the edge just passed.
// -----------------------------------------------------------------------------
module tb_riscv_dmem_if;

    localparam int XLEN = 64;
    localparam logic [2:0] SZ_BYTE  = 3'd0;
    localparam logic [2:0] SZ_HWORD = 3'd1;
    localparam logic [2:0] SZ_WORD  = 3'd2;
    localparam logic [2:0] SZ_DWORD = 3'd3;
    localparam logic [2:0] SZ_UNDEF = 3'd7;

    logic            clk = 1'b0;
    logic            rst;
    logic            mem_req;
    logic [XLEN-1:0] mem_adr;
    logic [XLEN-1:0] mem_d;
    logic            mem_we;
    logic [2:0]      mem_size;
    logic            mem_flush;
    logic            mem_full;
    logic            mem_ack;
    logic [XLEN-1:0] mem_q;
    logic            mem_misaligned;
    logic            mem_err;
    logic            bus_req;
    logic [XLEN-1:0] bus_adr;
    logic            bus_we;
    logic [2:0]      bus_size;
    logic [XLEN-1:0] bus_d;
    logic            bus_gnt;
    logic            bus_rvalid;
    logic [XLEN-1:0] bus_q;
    logic            bus_err;

    int n_cmp = 0;
    int n_bad = 0;

    riscv_dmem_if #(.XLEN(XLEN), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_adr        (mem_adr),
        .mem_d          (mem_d),
        .mem_we         (mem_we),
        .mem_size       (mem_size),
        .mem_flush      (mem_flush),
        .mem_full       (mem_full),
        .mem_ack        (mem_ack),
        .mem_q          (mem_q),
        .mem_misaligned (mem_misaligned),
        .mem_err        (mem_err),
        .bus_req        (bus_req),
        .bus_adr        (bus_adr),
        .bus_we         (bus_we),
        .bus_size       (bus_size),
        .bus_d          (bus_d),
        .bus_gnt        (bus_gnt),
        .bus_rvalid     (bus_rvalid),
        .bus_q          (bus_q),
        .bus_err        (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [63:0] adr, input logic [63:0] d,
                       input logic we, input logic [2:0] size);
        mem_req  = 1'b1;
        mem_adr  = adr;
        mem_d    = d;
        mem_we   = we;
        mem_size = size;
    endtask

    task automatic rsp(input logic [63:0] q, input logic err);
        bus_rvalid = 1'b1;
        bus_q      = q;
        bus_err    = err;
    endtask

    task automatic rsp_off();
        bus_rvalid = 1'b0;
        bus_err    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mem_req = 1'b0; mem_adr = '0; mem_d = '0; mem_we = 1'b0;
        mem_size = SZ_BYTE; mem_flush = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
        bus_q = '0; bus_err = 1'b0;

        // ---------------- reset state
        tick(); tick();
        check("rst_bus_req",  64'(bus_req), 64'd0);
        check("rst_mem_ack",  64'(mem_ack), 64'd0);
        check("rst_mem_full", 64'(mem_full), 64'd0);
        check("rst_mem_q",    mem_q, 64'd0);
        check("rst_bus_adr",  bus_adr, 64'd0);
        check("rst_bus_d",    bus_d, 64'd0);
        check("rst_bus_we",   64'(bus_we), 64'd0);
        check("rst_bus_size", 64'(bus_size), 64'(SZ_UNDEF));
        rst = 1'b0;
        tick();

        // ---------------- LW 0x1004, immediate grant
        bus_gnt = 1'b1;
        put(64'h1004, 64'h0, 1'b0, SZ_WORD);
        tick();                                   // E0: pushed
        mem_req = 1'b0;
        check("lw_req_e0", 64'(bus_req), 64'd0);
        tick();                                   // E1: issued
        check("lw_req_e1",  64'(bus_req), 64'd1);
        check("lw_adr",     bus_adr, 64'h1004);
        check("lw_size",    64'(bus_size), 64'(SZ_WORD));
        check("lw_we",      64'(bus_we), 64'd0);
        tick();                                   // granted
        check("lw_req_gnt", 64'(bus_req), 64'd0);
        rsp(64'hDEADBEEF_12345678, 1'b0);
        tick();
        rsp_off();
        check("lw_ack",  64'(mem_ack), 64'd1);
        check("lw_q",    mem_q, 64'h00000000_DEADBEEF);
        check("lw_mis",  64'(mem_misaligned), 64'd0);
        check("lw_err",  64'(mem_err), 64'd0);
        tick();
        check("lw_ack_pulse", 64'(mem_ack), 64'd0);

        // ---------------- SB 0x2003, LH 0x2002, LB 0x2001 with delayed grant
        bus_gnt = 1'b0;
        put(64'h2003, 64'h44000000, 1'b1, SZ_BYTE);
        tick();                                   // SB pushed
        put(64'h2002, 64'h0, 1'b0, SZ_HWORD);
        tick();                                   // LH pushed, SB issued
        check("b2b_sb_req",  64'(bus_req), 64'd1);
        check("b2b_sb_size", 64'(bus_size), 64'(SZ_BYTE));
        check("b2b_sb_adr",  bus_adr, 64'h2003);
        check("b2b_sb_we",   64'(bus_we), 64'd1);
        check("b2b_sb_d",    bus_d, 64'h44000000);
        check("b2b_full0",   64'(mem_full), 64'd0);
        put(64'h2001, 64'h0, 1'b0, SZ_BYTE);
        tick();                                   // LB pushed, queue full
        mem_req = 1'b0;
        check("b2b_full1", 64'(mem_full), 64'd1);
        tick(); tick();
        check("b2b_wait_req",  64'(bus_req), 64'd1);
        check("b2b_wait_full", 64'(mem_full), 64'd1);
        check("b2b_wait_ack",  64'(mem_ack), 64'd0);
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        check("b2b_sb_gnt", 64'(bus_req), 64'd0);
        rsp(64'hFFFFFFFF_FFFFFFFF, 1'b0);
        tick();
        rsp_off();
        check("b2b_sb_ack", 64'(mem_ack), 64'd1);
        check("b2b_sb_q",   mem_q, 64'd0);
        tick();                                   // idle cycle pops LH
        check("b2b_lh_req",  64'(bus_req), 64'd1);
        check("b2b_lh_size", 64'(bus_size), 64'(SZ_HWORD));
        check("b2b_lh_adr",  bus_adr, 64'h2002);
        check("b2b_full2",   64'(mem_full), 64'd0);
        check("b2b_ack_lo",  64'(mem_ack), 64'd0);
        bus_gnt = 1'b1;
        tick();
        rsp(64'h1111_2222_ABCD_3333, 1'b0);
        tick();
        rsp_off();
        check("b2b_lh_ack", 64'(mem_ack), 64'd1);
        check("b2b_lh_q",   mem_q, 64'h0000_0000_0000_ABCD);
        tick();                                   // pops LB
        check("b2b_lb_size", 64'(bus_size), 64'(SZ_BYTE));
        check("b2b_lb_adr",  bus_adr, 64'h2001);
        tick();
        rsp(64'h7777_0000_0000_5A00, 1'b0);
        tick();
        rsp_off();
        check("b2b_lb_ack", 64'(mem_ack), 64'd1);
        check("b2b_lb_q",   mem_q, 64'h5A);

        // ---------------- misaligned LW 0x1002, then SD 0x1008
        tick();
        put(64'h1002, 64'h0, 1'b0, SZ_WORD);
        tick();
        put(64'h1008, 64'hCAFE, 1'b1, SZ_DWORD);
        tick();                                   // LW popped as misaligned
        mem_req = 1'b0;
        check("mis_ack",   64'(mem_ack), 64'd1);
        check("mis_flag",  64'(mem_misaligned), 64'd1);
        check("mis_q",     mem_q, 64'd0);
        check("mis_nobus", 64'(bus_req), 64'd0);
        tick();                                   // SD issued
        check("mis_sd_req",  64'(bus_req), 64'd1);
        check("mis_sd_adr",  bus_adr, 64'h1008);
        check("mis_sd_size", 64'(bus_size), 64'(SZ_DWORD));
        check("mis_sd_d",    bus_d, 64'hCAFE);
        check("mis_pulse",   64'(mem_misaligned), 64'd0);
        tick();
        rsp(64'h0, 1'b0);
        tick();
        rsp_off();
        check("mis_sd_ack", 64'(mem_ack), 64'd1);
        check("mis_sd_mis", 64'(mem_misaligned), 64'd0);

        // ---------------- bus error on LD 0x3000
        tick();
        put(64'h3000, 64'h0, 1'b0, SZ_DWORD);
        tick();
        mem_req = 1'b0;
        tick(); tick();
        rsp(64'h1234, 1'b1);
        tick();
        rsp_off();
        check("err_ack", 64'(mem_ack), 64'd1);
        check("err_err", 64'(mem_err), 64'd1);
        check("err_q",   mem_q, 64'd0);
        tick();
        check("err_pulse", 64'(mem_err), 64'd0);

        // ---------------- flush with one in DATA and two queued
        put(64'h4000, 64'h0, 1'b0, SZ_DWORD);
        tick();
        put(64'h4008, 64'h0, 1'b0, SZ_DWORD);
        tick();                                   // A issued
        put(64'h4010, 64'h0, 1'b0, SZ_DWORD);
        tick();                                   // A granted, B and C queued
        mem_req = 1'b0;
        check("fl_full_pre", 64'(mem_full), 64'd1);
        mem_flush = 1'b1;
        tick();
        mem_flush = 1'b0;
        check("fl_full_post", 64'(mem_full), 64'd0);
        rsp(64'h5555, 1'b0);
        tick();
        rsp_off();
        check("fl_no_ack", 64'(mem_ack), 64'd0);
        tick();
        check("fl_no_issue", 64'(bus_req), 64'd0);
        check("fl_no_ack2",  64'(mem_ack), 64'd0);

        // ---------------- reset while in ADDR
        bus_gnt = 1'b0;
        put(64'h5000, 64'h0, 1'b0, SZ_WORD);
        tick();
        mem_req = 1'b0;
        tick();
        check("rs_req_pre", 64'(bus_req), 64'd1);
        rst = 1'b1;
        #1;
        check("rs_req_now",  64'(bus_req), 64'd0);
        check("rs_adr",      bus_adr, 64'd0);
        check("rs_size",     64'(bus_size), 64'(SZ_UNDEF));
        check("rs_full",     64'(mem_full), 64'd0);
        check("rs_q",        mem_q, 64'd0);
        tick();
        rst = 1'b0;
        rsp(64'h9999, 1'b0);
        tick();
        rsp_off();
        check("rs_late_rvalid", 64'(mem_ack), 64'd0);
        check("rs_idle_req",    64'(bus_req), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
